// File: rtl/nn_layer_sequencer.sv
// Sequences a multi-layer feed-forward pass through the 8-lane neuron layer, feeding outputs back as inputs.
// Latency: go -> first nrn_start in 3 cycles; each layer costs 3 + L cycles; done 1 cycle after the last finish.
// Backpressure: a single outstanding layer; go is ignored while busy, and a WAIT watchdog aborts a stuck layer.
module nn_layer_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int ADDR_W     = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [63:0]       x_in,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [511:0]      rom_wei,
  input  logic [63:0]       rom_bias,
  output logic              nrn_start,
  output logic [63:0]       nrn_inp,
  output logic [511:0]      nrn_wei,
  output logic [63:0]       nrn_bias,
  input  logic              nrn_finish,
  input  logic [63:0]       nrn_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [63:0]       result,
  output logic [2:0]        class_idx
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_LAYER = ADDR_W'(NUM_LAYERS - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT   = WD_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] layer;
  logic [63:0]       act;
  logic [WD_W-1:0]   wdog;
  logic [WD_W-1:0]   wdog_inc;
  logic              last_layer;
  logic              timeout_hit;

  assign wdog_inc    = wdog + WD_W'(1);
  assign last_layer  = (layer == LAST_LAYER);
  assign timeout_hit = (wdog_inc == WD_LIMIT);

  // Lowest-index lane holding the largest signed 8-bit value.
  function automatic logic [2:0] argmax(input logic [63:0] v);
    logic signed [7:0] best;
    logic [2:0]        idx;
    best = v[7:0];
    idx  = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if ($signed(v[8*i +: 8]) > best) begin
        best = v[8*i +: 8];
        idx  = 3'(i);
      end
    end
    return idx;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and the per-state control strobes.
  always_comb begin
    state_nxt = state;
    nrn_start = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        busy      = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy      = 1'b1;
        state_nxt = S_START;
      end
      S_START: begin
        busy      = 1'b1;
        nrn_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        // A finish landing on the timeout cycle is still honoured.
        if (nrn_finish)       state_nxt = last_layer ? S_DONE : S_FETCH;
        else if (timeout_hit) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: layer counter, activation feedback, ROM capture, watchdog and published result.
  // result/class_idx/err are written on entry to DONE so they are already valid alongside the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      layer     <= '0;
      act       <= '0;
      wdog      <= '0;
      rom_addr  <= '0;
      nrn_inp   <= '0;
      nrn_wei   <= '0;
      nrn_bias  <= '0;
      err       <= 1'b0;
      result    <= '0;
      class_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            act      <= x_in;
            layer    <= '0;
            rom_addr <= '0;
            err      <= 1'b0;
          end
        end
        S_LOAD: begin
          nrn_wei  <= rom_wei;
          nrn_bias <= rom_bias;
          nrn_inp  <= act;
        end
        S_START: begin
          wdog <= '0;
        end
        S_WAIT: begin
          wdog <= wdog_inc;
          if (nrn_finish) begin
            act <= nrn_out;
            if (last_layer) begin
              result    <= nrn_out;
              class_idx <= argmax(nrn_out);
            end else begin
              layer    <= layer + 1'b1;
              rom_addr <= layer + 1'b1;
            end
          end else if (timeout_hit) begin
            err       <= 1'b1;
            result    <= '0;
            class_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer with a synchronous ROM model and a fixed-latency neuron model.
// Latency: cycle numbers are counted from the cycle in which go is sampled (cycle 0).
// Backpressure: the neuron model answers L=5 cycles after nrn_start, or never when respond is cleared.
module tb_nn_layer_sequencer;

  logic          clk;
  logic          rst;
  logic          go;
  logic [63:0]   x_in;
  logic [1:0]    rom_addr;
  logic [511:0]  rom_wei;
  logic [63:0]   rom_bias;
  logic          nrn_start;
  logic [63:0]   nrn_inp;
  logic [511:0]  nrn_wei;
  logic [63:0]   nrn_bias;
  logic          nrn_finish;
  logic [63:0]   nrn_out;
  logic          busy;
  logic          done;
  logic          err;
  logic [63:0]   result;
  logic [2:0]    class_idx;

  int checks = 0;
  int errors = 0;

  nn_layer_sequencer #(.NUM_LAYERS(3), .ADDR_W(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .go(go), .x_in(x_in),
    .rom_addr(rom_addr), .rom_wei(rom_wei), .rom_bias(rom_bias),
    .nrn_start(nrn_start), .nrn_inp(nrn_inp), .nrn_wei(nrn_wei), .nrn_bias(nrn_bias),
    .nrn_finish(nrn_finish), .nrn_out(nrn_out),
    .busy(busy), .done(done), .err(err), .result(result), .class_idx(class_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int g = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] rom_w(input logic [1:0] a);
    logic [7:0] b;
    b = 8'hA0 + {6'd0, a};
    return {64{b}};
  endfunction

  function automatic logic [63:0] rom_b(input logic [1:0] a);
    logic [7:0] b;
    b = 8'h10 + {6'd0, a};
    return {8{b}};
  endfunction

  // Synchronous ROM: data follows rom_addr by one cycle.
  always @(posedge clk) begin
    rom_wei  <= rom_w(rom_addr);
    rom_bias <= rom_b(rom_addr);
  end

  bit          respond = 1'b1;
  bit          ovr_en  = 1'b0;
  bit          spur_en = 1'b0;
  logic [63:0] ovr_val = '0;
  int          lat = 5;
  int          stab_bad = 0;
  int          wei_bad = 0;
  int          st_cyc[$];
  logic [1:0]  st_addr[$];
  logic [63:0] st_inp[$];

  bit           pending = 1'b0;
  int           cnt = 0;
  logic [511:0] cap_w;
  logic [63:0]  cap_b;
  logic [63:0]  cap_i;

  // Neuron layer model, driven on the falling edge.
  always @(negedge clk) begin
    nrn_finish = 1'b0;
    if (rst) begin
      pending = 1'b0;
    end else begin
      if (spur_en && ((cyc - g) == 1 || (cyc - g) == 2)) begin
        nrn_finish = 1'b1;
        nrn_out    = 64'hDEAD_BEEF_0BAD_F00D;
      end
      if (nrn_start) begin
        pending = 1'b1;
        cnt     = 0;
        cap_w   = nrn_wei;
        cap_b   = nrn_bias;
        cap_i   = nrn_inp;
        st_cyc.push_back(cyc - g);
        st_addr.push_back(rom_addr);
        st_inp.push_back(nrn_inp);
        if (nrn_wei !== rom_w(rom_addr) || nrn_bias !== rom_b(rom_addr)) wei_bad++;
      end else if (pending) begin
        cnt++;
        if (busy && (nrn_wei !== cap_w || nrn_bias !== cap_b || nrn_inp !== cap_i)) stab_bad++;
        if (respond && cnt == lat) begin
          nrn_finish = 1'b1;
          nrn_out    = ovr_en ? ovr_val : cap_i + 64'h0101_0101_0101_0101;
          pending    = 1'b0;
        end
      end
    end
  end

  int          done_at;
  int          ndone;
  logic [63:0] r_res;
  logic [2:0]  r_cls;
  logic        r_err;
  logic        aft_busy;
  logic        aft_start;

  // One go pulse followed by ncyc observed cycles; optional go injection at cycles 5/25 and a reset at rst_at.
  task automatic run_pass(input int ncyc, input bit inj_go, input int rst_at);
    int k;
    st_cyc.delete();
    st_addr.delete();
    st_inp.delete();
    stab_bad = 0;
    wei_bad  = 0;
    done_at  = -1;
    ndone    = 0;
    @(negedge clk);
    go = 1'b1;
    g  = cyc;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      k   = cyc - g;
      go  = inj_go && (k == 5 || k == 25);
      rst = (k == rst_at);
      if (k == rst_at + 1) begin
        aft_busy  = busy;
        aft_start = nrn_start;
      end
      if (done) begin
        ndone++;
        if (done_at < 0) begin
          done_at = k;
          r_res   = result;
          r_cls   = class_idx;
          r_err   = err;
        end
      end
    end
    go  = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    go   = 1'b0;
    x_in = '0;
    repeat (3) @(negedge clk);
    checks++; if (nrn_start !== 1'b0) begin errors++; $display("FAIL reset_nrn_start got %b want 0", nrn_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (class_idx !== 3'd0) begin errors++; $display("FAIL reset_class got %0d want 0", class_idx); end
    checks++; if (rom_addr !== 2'd0) begin errors++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
    checks++; if (nrn_wei !== 512'd0 || nrn_inp !== 64'd0 || nrn_bias !== 64'd0) begin
      errors++; $display("FAIL reset_nrn_regs inp %h bias %h want 0", nrn_inp, nrn_bias);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int starts = 0;
    int busies = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (nrn_start) starts++;
      if (busy) busies++;
    end
    checks++; if (starts !== 0) begin errors++; $display("FAIL idle_starts got %0d want 0", starts); end
    checks++; if (busies !== 0) begin errors++; $display("FAIL idle_busy got %0d want 0", busies); end
  endtask

  task automatic test_three_layers();
    int          exp_cyc[3] = '{3, 11, 19};
    logic [63:0] exp_inp[3] = '{64'h0, 64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202};
    x_in = '0;
    run_pass(40, 1'b0, -1);
    checks++;
    if (st_cyc.size() !== 3) begin
      errors++; $display("FAIL main_start_count got %0d want 3", st_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (st_cyc[i] !== exp_cyc[i]) begin errors++; $display("FAIL main_start_cycle[%0d] got %0d want %0d", i, st_cyc[i], exp_cyc[i]); end
        checks++; if (st_addr[i] !== 2'(i)) begin errors++; $display("FAIL main_rom_addr[%0d] got %0d want %0d", i, st_addr[i], i); end
        checks++; if (st_inp[i] !== exp_inp[i]) begin errors++; $display("FAIL main_inp[%0d] got %h want %h", i, st_inp[i], exp_inp[i]); end
      end
    end
    checks++; if (done_at !== 25) begin errors++; $display("FAIL main_done_cycle got %0d want 25", done_at); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL main_done_count got %0d want 1", ndone); end
    checks++; if (r_res !== 64'h0303_0303_0303_0303) begin errors++; $display("FAIL main_result got %h want 0303030303030303", r_res); end
    checks++; if (r_cls !== 3'd0) begin errors++; $display("FAIL main_class got %0d want 0", r_cls); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL main_err got %b want 0", r_err); end
    checks++; if (wei_bad !== 0) begin errors++; $display("FAIL main_rom_capture got %0d bad want 0", wei_bad); end
    checks++; if (stab_bad !== 0) begin errors++; $display("FAIL main_wait_stable got %0d bad want 0", stab_bad); end
  endtask

  task automatic test_argmax();
    logic [63:0] vec[3] = '{64'h0000_7F00_007F_0080, 64'hFFFF_FFFF_FFFF_FFFF, 64'h05FE_FEFE_FEFE_FEFE};
    logic [2:0]  exp[3] = '{3'd2, 3'd0, 3'd7};
    ovr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ovr_val = vec[i];
      run_pass(40, 1'b0, -1);
      checks++; if (r_cls !== exp[i]) begin errors++; $display("FAIL argmax_class[%0d] got %0d want %0d", i, r_cls, exp[i]); end
      checks++; if (r_res !== vec[i]) begin errors++; $display("FAIL argmax_result[%0d] got %h want %h", i, r_res, vec[i]); end
    end
    ovr_en = 1'b0;
  endtask

  task automatic test_handshake_robust();
    x_in    = 64'h10F0_0000_0000_0000;
    spur_en = 1'b1;
    run_pass(40, 1'b1, -1);
    spur_en = 1'b0;
    checks++; if (done_at !== 25) begin errors++; $display("FAIL robust_done_cycle got %0d want 25", done_at); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL robust_done_count got %0d want 1", ndone); end
    checks++; if (r_res !== 64'h13F3_0303_0303_0303) begin errors++; $display("FAIL robust_result got %h want 13f3030303030303", r_res); end
    checks++; if (r_cls !== 3'd7) begin errors++; $display("FAIL robust_class got %0d want 7", r_cls); end
    checks++; if (stab_bad !== 0) begin errors++; $display("FAIL robust_wait_stable got %0d bad want 0", stab_bad); end
    x_in = '0;
  endtask

  task automatic test_timeout();
    respond = 1'b0;
    run_pass(30, 1'b0, -1);
    respond = 1'b1;
    checks++; if (done_at !== 20) begin errors++; $display("FAIL timeout_done_cycle got %0d want 20", done_at); end
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL timeout_err got %b want 1", r_err); end
    checks++; if (r_res !== 64'd0) begin errors++; $display("FAIL timeout_result got %h want 0", r_res); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL timeout_done_count got %0d want 1", ndone); end
    run_pass(40, 1'b0, -1);
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL timeout_err_cleared got %b want 0", r_err); end
    checks++; if (done_at !== 25) begin errors++; $display("FAIL timeout_recover_done got %0d want 25", done_at); end
  endtask

  task automatic test_reset_mid_wait();
    run_pass(40, 1'b0, 13);
    checks++; if (aft_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", aft_busy); end
    checks++; if (aft_start !== 1'b0) begin errors++; $display("FAIL midrst_start got %b want 0", aft_start); end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL midrst_done_count got %0d want 0", ndone); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL midrst_result got %h want 0", result); end
    run_pass(40, 1'b0, -1);
    checks++;
    if (st_addr.size() < 1) begin
      errors++; $display("FAIL midrst_restart got no start want rom_addr 0");
    end else if (st_addr[0] !== 2'd0 || st_cyc[0] !== 3) begin
      errors++; $display("FAIL midrst_restart got addr %0d cycle %0d want addr 0 cycle 3", st_addr[0], st_cyc[0]);
    end
    checks++; if (done_at !== 25) begin errors++; $display("FAIL midrst_done_cycle got %0d want 25", done_at); end
  endtask

  initial begin
    rst        = 1'b1;
    go         = 1'b0;
    x_in       = '0;
    nrn_finish = 1'b0;
    nrn_out    = '0;
    test_reset();
    test_idle();
    test_three_layers();
    test_argmax();
    test_handshake_robust();
    test_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_layer_sequencer.md
Name: nn_layer_sequencer

Overview:
- Initiator that drives the 8-lane neuron layer through its start/finish handshake.
- Runs a multi-layer feed-forward pass: fetches per-layer weights (512b) and biases (64b) from a synchronous ROM, starts the layer, captures the 64-bit output and feeds it back as the next layer's input.
- On completion, publishes the final activation vector plus an argmax class index.
- Sits between the top-level inference control and the neuron layer.

Parameters:
- NUM_LAYERS, 3, number of layers evaluated per inference (1..2^ADDR_W).
- ADDR_W, 2, width of the ROM layer address.
- TIMEOUT, 1023, maximum cycles spent in WAIT before abort.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- go  in  1  start inference; sampled only in IDLE
- x_in  in  64  initial input vector, 8 lanes x 8b signed, lane i = [8i+7:8i]
- rom_addr  out  ADDR_W  layer index presented to weight/bias ROM
- rom_wei  in  512  ROM weight word, valid 1 cycle after rom_addr
- rom_bias  in  64  ROM bias word, valid 1 cycle after rom_addr
- nrn_start  out  1  one-cycle start pulse to neuron layer
- nrn_inp  out  64  layer input vector (registered)
- nrn_wei  out  512  layer weights (registered)
- nrn_bias  out  64  layer biases (registered)
- nrn_finish  in  1  layer complete; nrn_out valid in the same cycle
- nrn_out  in  64  layer output vector
- busy  out  1  high in FETCH, LOAD, START, WAIT
- done  out  1  one-cycle completion pulse
- err  out  1  timeout flag, valid with done, held until next go
- result  out  64  final activation vector, held until next completion
- class_idx  out  3  argmax lane of result

Behaviour:
- Reset: all outputs 0; state IDLE; layer counter 0; activation register 0; watchdog 0.
- rst has priority in every state. Mid-run reset aborts immediately: no done, nrn_start low next cycle.
- IDLE: on go, act <= x_in, layer <= 0, err <= 0 -> FETCH. Otherwise stay.
- FETCH: rom_addr = layer -> LOAD.
- LOAD: nrn_wei <= rom_wei, nrn_bias <= rom_bias, nrn_inp <= act -> START.
- START: nrn_start = 1 for exactly this cycle; watchdog <= 0 -> WAIT.
- WAIT:
  - nrn_inp, nrn_wei and nrn_bias stay stable throughout.
  - Watchdog increments each cycle.
  - nrn_finish is recognised only in WAIT; a finish in any other state is ignored.
  - On nrn_finish: act <= nrn_out. If layer == NUM_LAYERS-1 -> DONE, else layer <= layer+1 -> FETCH.
  - If watchdog reaches TIMEOUT without finish: err <= 1 -> DONE.
  - If finish and timeout occur in the same cycle, finish wins.
- DONE:
  - done = 1 for one cycle.
  - result <= act, or 0 on err.
  - class_idx <= argmax of the new result -> IDLE.
- Argmax: lanes compared as signed 8-bit; the lowest index wins ties; an all-equal vector gives 0.
- go asserted while not IDLE (including DONE) is ignored; it is not queued.
- Latency: go sampled at cycle 0 -> nrn_start at cycle 3. Each layer costs 3 + L cycles, where L = cycles from nrn_start to nrn_finish. done arrives 1 cycle after the last finish.
- rom_addr holds its last value outside FETCH.
- The layer counter never exceeds NUM_LAYERS-1; no wrap.

Test Plan:
- Reset then idle: all outputs 0; go=0 for 20 cycles -> nrn_start never asserts, busy=0.
- NUM_LAYERS=3, neuron model with fixed L=5 returning nrn_out = inp + 0x0101..01:
  - x_in = 0 -> nrn_start at cycles 3, 11, 19.
  - rom_addr sequence 0, 1, 2.
  - done at cycle 25; result = 0x0303030303030303; class_idx = 0; err = 0.
- Argmax signed and tie handling:
  - final nrn_out with lane2 = 0x7F, lane5 = 0x7F, lane0 = 0x80 (-128) -> class_idx = 2.
  - final nrn_out of all 0xFF -> class_idx = 0.
- Handshake robustness:
  - spurious nrn_finish during FETCH/LOAD is ignored.
  - go pulsed during WAIT and during DONE is ignored: exactly one done per accepted go.
  - nrn_wei and nrn_bias are stable across all WAIT cycles.
- Timeout: TIMEOUT=16, neuron never finishes -> done 17 cycles after nrn_start, err=1, result=0. The next go clears err.
- Reset mid-WAIT during layer 1 -> next cycle busy=0, nrn_start=0, done never pulses, result=0. A new go restarts at rom_addr=0.
